// File: rtl/osc_pkg.sv
// Shared widths, FSM encoding and trigger constants for the waveform capture path.
`timescale 1ns/1ps
package osc_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DECIM_W  = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  localparam logic TRIG_RISE = 1'b0;
  localparam logic TRIG_FALL = 1'b1;

  // Settings snapshot taken at each arm
  typedef struct packed {
    logic [DECIM_W-1:0]  decim;
    logic [SAMPLE_W-1:0] level;
    logic                slope;
  } arm_cfg_t;

endpackage

// File: rtl/wave_capture_wr_if.sv
// ADC sample stream in and waveform-RAM write port out, bundled for the capture block.
`timescale 1ns/1ps
interface wave_capture_wr_if;
  import osc_pkg::*;

  logic                adc_valid;
  logic [SAMPLE_W-1:0] adc_data;
  logic                ram_wr_en;
  logic [ADDR_W-1:0]   ram_wr_addr;
  logic [SAMPLE_W-1:0] ram_wr_data;

  modport master (
    output adc_valid, adc_data,
    input  ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport slave (
    input  adc_valid, adc_data,
    output ram_wr_en, ram_wr_addr, ram_wr_data
  );

endinterface

// File: rtl/wave_trig_detect.sv
// Combinational level-crossing detector between the previous and current accepted sample.
`timescale 1ns/1ps
module wave_trig_detect
  import osc_pkg::*;
(
  input  logic [SAMPLE_W-1:0] prev,
  input  logic [SAMPLE_W-1:0] cur,
  input  logic                prev_valid,
  input  logic [SAMPLE_W-1:0] level,
  input  logic                slope,
  output logic                hit_c
);

  always_comb begin
    hit_c = 1'b0;
    if (prev_valid) begin
      if (slope == TRIG_RISE) begin
        hit_c = (prev < level) && (cur >= level);
      end else begin
        hit_c = (prev > level) && (cur <= level);
      end
    end
  end

endmodule

// File: rtl/wave_capture_wr.sv
// Decimating, triggered capture of one screen-width record into the waveform RAM,
// held until the display finishes a frame so scan-out never sees a half-written trace.
`timescale 1ns/1ps
module wave_capture_wr
  import osc_pkg::*;
#(
  parameter int unsigned DEPTH        = 640,
  parameter int unsigned AUTO_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [DECIM_W-1:0]  decim,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_slope,
  input  logic                frame_end,
  wave_capture_wr_if.slave    bus,
  output logic                busy,
  output logic                capture_done,
  output logic                auto_trig
);

  localparam int unsigned       TO_W      = $clog2(AUTO_TIMEOUT + 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(AUTO_TIMEOUT);
  localparam bit                AUTO_EN   = (AUTO_TIMEOUT != 0);

  logic [1:0]          state_q, state_d;
  arm_cfg_t            cfg_q, cfg_d;
  logic [DECIM_W-1:0]  dcnt_q, dcnt_d;
  logic [TO_W-1:0]     timeout_q, timeout_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                auto_q, auto_d;

  logic accept_c;
  logic hit_c;
  logic do_write_c;
  logic arm_c;

  assign accept_c = bus.adc_valid && (dcnt_q == '0);

  wave_trig_detect u_trig (
    .prev       (prev_q),
    .cur        (bus.adc_data),
    .prev_valid (prev_valid_q),
    .level      (cfg_q.level),
    .slope      (cfg_q.slope),
    .hit_c      (hit_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      dcnt_q       <= '0;
      timeout_q    <= '0;
      addr_q       <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      auto_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      dcnt_q       <= dcnt_d;
      timeout_q    <= timeout_d;
      addr_q       <= addr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      auto_q       <= auto_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    dcnt_d       = dcnt_q;
    timeout_d    = timeout_q;
    addr_d       = addr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;
    auto_d       = auto_q;
    do_write_c   = 1'b0;
    arm_c        = 1'b0;

    if (bus.adc_valid) begin
      dcnt_d = accept_c ? cfg_q.decim : dcnt_q - DECIM_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (run) arm_c = 1'b1;
      end
      ST_ARMED: begin
        if (accept_c) begin
          prev_d       = bus.adc_data;
          prev_valid_d = 1'b1;
          if (hit_c) begin
            do_write_c = 1'b1;
          end else if (AUTO_EN && (timeout_q + TO_W'(1) == TO_LIMIT)) begin
            do_write_c = 1'b1;
            auto_d     = 1'b1;
          end else if (AUTO_EN) begin
            timeout_d = timeout_q + TO_W'(1);
          end
        end
      end
      ST_CAPTURE: begin
        if (accept_c) do_write_c = 1'b1;
      end
      ST_HOLD: begin
        if (frame_end) begin
          if (run) arm_c = 1'b1;
          else     state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered write; the record ends on the last address without wrapping
    if (do_write_c) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = bus.adc_data;
      if (addr_q == LAST_ADDR) begin
        done_d  = 1'b1;
        state_d = ST_HOLD;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_CAPTURE;
      end
    end

    if (arm_c) begin
      cfg_d        = '{decim: decim, level: trig_level, slope: trig_slope};
      dcnt_d       = '0;
      timeout_d    = '0;
      addr_d       = '0;
      prev_valid_d = 1'b0;
      auto_d       = 1'b0;
      state_d      = ST_ARMED;
    end

    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
  end

  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_wr_addr = wr_addr_q;
  assign bus.ram_wr_data = wr_data_q;
  assign busy            = busy_q;
  assign capture_done    = done_q;
  assign auto_trig       = auto_q;

endmodule
